// File: rtl/pp2verilog_vga_timing_if.sv
// pp2verilog_vga_timing_if: raster coordinates, colour return path and DAC pins
interface pp2verilog_vga_timing_if;
    logic [9:0] xPixel;
    logic [8:0] yPixel;
    logic       inActive;
    logic       frameStart;
    logic [7:0] VGAr;
    logic [7:0] VGAg;
    logic [7:0] VGAb;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;
    modport master (
        output xPixel, yPixel, inActive, frameStart,
        input  VGAr, VGAg, VGAb,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
    );
    modport slave (
        input  xPixel, yPixel, inActive, frameStart,
        output VGAr, VGAg, VGAb,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
    );
endinterface

// File: rtl/pp2verilog_vga_timing.sv
// pp2verilog_vga_timing: 640x480 raster timing with one-pixel registered colour/sync output stage
// Define VGA_TIMING_TESTPAT_EN to replace the colour return with eight vertical colour bars.
module pp2verilog_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input logic clk,
    input logic reset,
    pp2verilog_vga_timing_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    logic [DW-1:0] div_cnt, div_nxt;
    logic [9:0] h_cnt, v_cnt;
    logic pix_en, active, hs, vs;
    logic [7:0] r, g, b;
`ifdef VGA_TIMING_TESTPAT_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    logic [2:0] bar;
`endif

    always_comb begin
        pix_en = div_cnt == DIV_LAST;
        div_nxt = pix_en ? '0 : div_cnt + 1'b1;
        active = h_cnt < H_ACT && v_cnt < V_ACT;
        hs = h_cnt >= HS_ON && h_cnt < HS_OFF;
        vs = v_cnt >= VS_ON && v_cnt < VS_OFF;
`ifdef VGA_TIMING_TESTPAT_EN
        // bar index bits map directly onto the absent colour channels
        bar = 3'(h_cnt / BAR_W);
        r = {8{~bar[1]}};
        g = {8{~bar[2]}};
        b = {8{~bar[0]}};
`else
        r = vga.VGAr;
        g = vga.VGAg;
        b = vga.VGAb;
`endif
    end

    assign vga.xPixel     = active ? h_cnt : '0;
    assign vga.yPixel     = active ? v_cnt[8:0] : '0;
    assign vga.inActive   = active;
    assign vga.frameStart = pix_en && h_cnt == '0 && v_cnt == '0;
    assign vga.VGA_SYNC_N = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt         <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            vga.VGA_R       <= '0;
            vga.VGA_G       <= '0;
            vga.VGA_B       <= '0;
            vga.VGA_BLANK_N <= 1'b0;
            vga.VGA_HS      <= ~SYNC_POL;
            vga.VGA_VS      <= ~SYNC_POL;
            vga.VGA_CLK     <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            // low for the first half of each pixel so the DAC samples mid-pixel
            vga.VGA_CLK <= div_nxt >= DIV_HALF;
            if (pix_en) begin
                h_cnt <= h_cnt == H_LAST ? '0 : h_cnt + 1'b1;
                if (h_cnt == H_LAST)
                    v_cnt <= v_cnt == V_LAST ? '0 : v_cnt + 1'b1;
                vga.VGA_R       <= active ? r : '0;
                vga.VGA_G       <= active ? g : '0;
                vga.VGA_B       <= active ? b : '0;
                vga.VGA_BLANK_N <= active;
                vga.VGA_HS      <= hs ? SYNC_POL : ~SYNC_POL;
                vga.VGA_VS      <= vs ? SYNC_POL : ~SYNC_POL;
            end
        end
    end
endmodule

// File: tb/tb_pp2verilog_vga_timing.sv
// tb_pp2verilog_vga_timing: directed vectors for the VGA timing generator (vertical timing shortened to 12 lines)
module tb_pp2verilog_vga_timing;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    int pos = 0;

    pp2verilog_vga_timing_if vga();

    pp2verilog_vga_timing #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut (
        .clk(clk),
        .reset(reset),
        .vga(vga)
    );

    always #5 clk = ~clk;

    always_comb begin
        vga.VGAr = vga.xPixel[7:0];
        vga.VGAg = vga.yPixel[7:0];
        vga.VGAb = 8'h5A;
    end

    typedef struct {
        int f;
        int h;
        int v;
        logic fs;
        logic bn;
        logic hs;
        logic vs;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    task automatic tick();
        @(negedge clk);
        pos++;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int h, input int v);
        if (h >= 640 || v >= 6) return 24'h0;
`ifdef VGA_TIMING_TESTPAT_EN
        case (h / 80)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return {8'(h), 8'(v), 8'h5A};
`endif
    endfunction

    initial begin
        int f1, f2, r1, br, bf, vf, vr, fs_at, maxx, maxy, leak, w;
        logic phs, pbn, pvs;
        tbl = '{
            '{0,   0,  0, 1'b1, 1'b1, 1'b1, 1'b1},
            '{0,  79,  0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0,  80,  0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0, 100,  0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0, 256,  0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0, 639,  0, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0, 640,  0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0, 655,  0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0, 656,  0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{0, 751,  0, 1'b0, 1'b0, 1'b0, 1'b1},
            '{0, 752,  0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0, 799,  0, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0, 100,  5, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0, 639,  5, 1'b0, 1'b1, 1'b1, 1'b1},
            '{0,   0,  6, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0,   0,  8, 1'b0, 1'b0, 1'b1, 1'b0},
            '{0, 700,  9, 1'b0, 1'b0, 1'b0, 1'b0},
            '{0,   0, 10, 1'b0, 1'b0, 1'b1, 1'b1},
            '{0, 799, 11, 1'b0, 1'b0, 1'b1, 1'b1},
            '{1,   0,  0, 1'b1, 1'b1, 1'b1, 1'b1}
        };

        repeat (10) tick();
        chk("rst_x", 0, 32'(vga.xPixel), 0);
        chk("rst_y", 0, 32'(vga.yPixel), 0);
        chk("rst_act", 0, 32'(vga.inActive), 1);
        chk("rst_fs", 0, 32'(vga.frameStart), 0);
        chk("rst_rgb", 0, 32'({vga.VGA_R, vga.VGA_G, vga.VGA_B}), 0);
        chk("rst_bn", 0, 32'(vga.VGA_BLANK_N), 0);
        chk("rst_hsvs", 0, 32'({vga.VGA_HS, vga.VGA_VS}), 3);
        chk("rst_clk", 0, 32'(vga.VGA_CLK), 0);
        chk("rst_syncn", 0, 32'(vga.VGA_SYNC_N), 0);

        reset = 1'b0;
        pos = 0;
        for (int i = 0; i < NV; i++) begin
            int k, h, v;
            logic act;
            h = tbl[i].h;
            v = tbl[i].v;
            k = tbl[i].f * 9600 + v * 800 + h;
            act = h < 640 && v < 6;
            while (pos < 2 * k + 1) tick();
            chk("xPixel", i, 32'(vga.xPixel), 32'(act ? h : 0));
            chk("yPixel", i, 32'(vga.yPixel), 32'(act ? v : 0));
            chk("inActive", i, 32'(vga.inActive), 32'(act));
            chk("frameStart", i, 32'(vga.frameStart), 32'(tbl[i].fs));
            chk("vgaclk_hi", i, 32'(vga.VGA_CLK), 1);
            tick();
            chk("rgb", i, 32'({vga.VGA_R, vga.VGA_G, vga.VGA_B}), 32'(exp_rgb(h, v)));
            chk("blank_n", i, 32'(vga.VGA_BLANK_N), 32'(tbl[i].bn));
            chk("hs", i, 32'(vga.VGA_HS), 32'(tbl[i].hs));
            chk("vs", i, 32'(vga.VGA_VS), 32'(tbl[i].vs));
            chk("vgaclk_lo", i, 32'(vga.VGA_CLK), 0);
        end

        f1 = -1; f2 = -1; r1 = -1; br = -1; bf = -1; vf = -1; vr = -1; fs_at = -1;
        maxx = 0; maxy = 0; leak = 0;
        phs = vga.VGA_HS; pbn = vga.VGA_BLANK_N; pvs = vga.VGA_VS;
        repeat (20000) begin
            tick();
            if (phs && !vga.VGA_HS) begin
                if (f1 < 0) f1 = pos;
                else if (f2 < 0) f2 = pos;
            end
            if (!phs && vga.VGA_HS && f1 >= 0 && r1 < 0) r1 = pos;
            if (!pbn && vga.VGA_BLANK_N && br < 0) br = pos;
            if (pbn && !vga.VGA_BLANK_N && br >= 0 && bf < 0) bf = pos;
            if (pvs && !vga.VGA_VS && vf < 0) vf = pos;
            if (!pvs && vga.VGA_VS && vf >= 0 && vr < 0) vr = pos;
            if (vga.frameStart && fs_at < 0) fs_at = pos;
            if (int'(vga.xPixel) > maxx) maxx = int'(vga.xPixel);
            if (int'(vga.yPixel) > maxy) maxy = int'(vga.yPixel);
            if (!vga.VGA_BLANK_N && {vga.VGA_R, vga.VGA_G, vga.VGA_B} != 24'h0) leak++;
            phs = vga.VGA_HS; pbn = vga.VGA_BLANK_N; pvs = vga.VGA_VS;
        end
        chk("hs_period", 0, 32'(f2 - f1), 1600);
        chk("hs_low", 0, 32'(r1 - f1), 192);
        chk("blank_hi", 0, 32'(bf - br), 1280);
        chk("vs_low", 0, 32'(vr - vf), 3200);
        chk("fs_period", 0, 32'(fs_at), 38401);
        chk("max_x", 0, 32'(maxx), 639);
        chk("max_y", 0, 32'(maxy), 5);
        chk("blank_leak", 0, 32'(leak), 0);

        w = 0;
        while (!(vga.xPixel == 10'd300 && vga.yPixel == 9'd3) && w < 20000) begin
            tick();
            w++;
        end
        chk("reach_300_3", 0, 32'(w < 20000), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_x", 0, 32'(vga.xPixel), 0);
        chk("mid_rst_y", 0, 32'(vga.yPixel), 0);
        chk("mid_rst_act", 0, 32'(vga.inActive), 1);
        chk("mid_rst_fs", 0, 32'(vga.frameStart), 0);
        chk("mid_rst_rgb", 0, 32'({vga.VGA_R, vga.VGA_G, vga.VGA_B}), 0);
        chk("mid_rst_bn", 0, 32'(vga.VGA_BLANK_N), 0);
        chk("mid_rst_hsvs", 0, 32'({vga.VGA_HS, vga.VGA_VS}), 3);
        chk("mid_rst_clk", 0, 32'(vga.VGA_CLK), 0);
        reset = 1'b0;
        tick();
        chk("restart_fs", 0, 32'(vga.frameStart), 1);
        chk("restart_bn", 0, 32'(vga.VGA_BLANK_N), 0);
        tick();
        chk("restart_fs_end", 0, 32'(vga.frameStart), 0);
        chk("restart_bn_hi", 0, 32'(vga.VGA_BLANK_N), 1);
        chk("restart_rgb", 0, 32'({vga.VGA_R, vga.VGA_G, vga.VGA_B}), 32'(exp_rgb(0, 0)));
        chk("restart_x", 0, 32'(vga.xPixel), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
